// File: rtl/max_err_monitor.sv
//==============================================================================
// max_err_monitor -- compares exact/approx max-circuit words over a fixed run.
// Optional macro MAX_ERR_ABS_EN builds absolute-error tracking.  Rev 1.0
//==============================================================================
`default_nettype none

module max_err_monitor #(
    parameter int W         = 5,
    parameter int CNT_W     = 16,
    parameter int N_SAMPLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     exact,
    input  logic [W-1:0]     approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_err_sum,
    output logic [W-1:0]     max_abs_err
);

    localparam int PW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             drain_q, drain_d;
    logic             s1_valid_q;
    logic [W-1:0]     s1_xor_q;
    logic [CNT_W-1:0] sample_q, err_q, bits_q;
    logic             xfer, run_start, last_xfer;
    logic [PW-1:0]    pop;
    logic [CNT_W:0]   bits_sum;

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign xfer      = in_valid && in_ready;
    assign run_start = (state_q == S_IDLE) && start;
    assign last_xfer = xfer && (sample_q == CNT_W'(N_SAMPLES - 1));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (last_xfer) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_DONE;
                drain_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) pop = pop + PW'(s1_xor_q[i]);
    end

    // One extra bit catches the carry so the sum clamps instead of wrapping.
    assign bits_sum = {1'b0, bits_q} + (CNT_W + 1)'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_xor_q   <= '0;
            sample_q   <= '0;
            err_q      <= '0;
            bits_q     <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            s1_valid_q <= xfer;
            s1_xor_q   <= exact ^ approx;
            if (run_start) begin
                sample_q <= '0;
                err_q    <= '0;
                bits_q   <= '0;
            end else begin
                if (xfer) sample_q <= sample_q + 1'b1;
                if (s1_valid_q) begin
                    if ((s1_xor_q != '0) && (err_q != '1)) err_q <= err_q + 1'b1;
                    bits_q <= bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
                end
            end
        end
    end

`ifdef MAX_ERR_ABS_EN
    logic [W-1:0] s1_diff_q, max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_diff_q <= '0;
            max_q     <= '0;
        end else begin
            s1_diff_q <= (exact >= approx) ? (exact - approx) : (approx - exact);
            if (run_start)
                max_q <= '0;
            else if (s1_valid_q && (s1_diff_q > max_q))
                max_q <= s1_diff_q;
        end
    end

    assign max_abs_err = max_q;
`else
    assign max_abs_err = '0;
`endif

    assign sample_count = sample_q;
    assign err_count    = err_q;
    assign bit_err_sum  = bits_q;

endmodule

`default_nettype wire

// File: tb/tb_max_err_monitor.sv
//==============================================================================
// tb_max_err_monitor -- table-driven, scoreboard-checked bench for max_err_monitor.
// Honours MAX_ERR_ABS_EN for the expected max_abs_err.  Rev 1.0
//==============================================================================
`default_nettype none

module tb_max_err_monitor;

    localparam int W     = 5;
    localparam int CNT_W = 8;
`ifdef MAX_ERR_ABS_EN
    localparam bit ABS_EN = 1'b1;
`else
    localparam bit ABS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][W-1:0] ex;
        logic [3:0][W-1:0] ap;
        logic              tg;
        logic [CNT_W-1:0]  err;
        logic [CNT_W-1:0]  bits;
        logic [W-1:0]      mx;
    } vec_t;

    typedef struct packed {
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] err;
        logic [CNT_W-1:0] bits;
        logic [W-1:0]     mx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0;
    logic [W-1:0] exact = '0, approx = '0;
    logic in_ready, busy, done;
    logic [CNT_W-1:0] sample_count, err_count, bit_err_sum;
    logic [W-1:0] max_abs_err;

    logic start2 = 1'b0, in_valid2 = 1'b0;
    logic [W-1:0] exact2 = '0, approx2 = '0;
    logic in_ready2, busy2, done2;
    logic [CNT_W-1:0] sample_count2, err_count2, bit_err_sum2;
    logic [W-1:0] max_abs_err2;

    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    max_err_monitor #(.W(W), .CNT_W(CNT_W), .N_SAMPLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .exact(exact), .approx(approx), .busy(busy),
        .done(done), .sample_count(sample_count), .err_count(err_count),
        .bit_err_sum(bit_err_sum), .max_abs_err(max_abs_err)
    );

    max_err_monitor #(.W(W), .CNT_W(CNT_W), .N_SAMPLES(200)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid2),
        .in_ready(in_ready2), .exact(exact2), .approx(approx2), .busy(busy2),
        .done(done2), .sample_count(sample_count2), .err_count(err_count2),
        .bit_err_sum(bit_err_sum2), .max_abs_err(max_abs_err2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] e0, a0, e1, a1, e2, a2, e3, a3,
                                input logic tg, input int er, bs, mx);
        vec_t v;
        v.ex[0] = e0; v.ap[0] = a0; v.ex[1] = e1; v.ap[1] = a1;
        v.ex[2] = e2; v.ap[2] = a2; v.ex[3] = e3; v.ap[3] = a3;
        v.tg   = tg;
        v.err  = CNT_W'(er);
        v.bits = CNT_W'(bs);
        v.mx   = ABS_EN ? W'(mx) : '0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input bit mid_start, input string nm);
        exp_t e;
        int idx = 0;
        int cyc = 0;
        bit xf;
        sb.push_back('{sc: CNT_W'(4), err: v.err, bits: v.bits, mx: v.mx});
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({nm, " busy after start"}, busy, 1);
        chk({nm, " in_ready after start"}, in_ready, 1);
        chk({nm, " cleared"}, {sample_count, err_count, bit_err_sum}, 0);
        while (idx < 4 && cyc < 40) begin
            in_valid = v.tg ? ((cyc % 2) == 0) : 1'b1;
            exact    = v.ex[idx];
            approx   = v.ap[idx];
            start    = mid_start && (cyc == 3);
            xf       = in_valid && in_ready;
            @(negedge clk);
            if (xf) idx++;
            cyc++;
        end
        start = 1'b0;
        if (idx < 4) chk({nm, " transfer timeout"}, idx, 4);
        in_valid = 1'b1;
        chk({nm, " in_ready drops"}, in_ready, 0);
        chk({nm, " count after last"}, sample_count, 4);
        @(negedge clk);
        chk({nm, " drain done low"}, {done, busy}, 1);
        @(negedge clk);
        chk({nm, " done/busy"}, {done, busy}, 2);
        e = sb.pop_front();
        chk({nm, " sample_count"}, sample_count, e.sc);
        chk({nm, " err_count"}, err_count, e.err);
        chk({nm, " bit_err_sum"}, bit_err_sum, e.bits);
        chk({nm, " max_abs_err"}, max_abs_err, e.mx);
        @(negedge clk);
        chk({nm, " idle after done"}, {done, busy, in_ready}, 0);
        chk({nm, " results stable"}, {sample_count, err_count, bit_err_sum, max_abs_err},
            {e.sc, e.err, e.bits, e.mx});
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        vecs[0] = mk(3, 3, 7, 7, 0, 0, 31, 31, 1'b0, 0, 0, 0);
        vecs[1] = mk(5, 4, 16, 0, 9, 9, 31, 0, 1'b0, 3, 7, 31);
        vecs[2] = mk(1, 2, 8, 8, 20, 10, 0, 6, 1'b1, 3, 8, 10);
        vecs[3] = mk(2, 3, 0, 0, 4, 4, 12, 3, 1'b0, 2, 5, 9);

        repeat (2) @(negedge clk);
        chk("reset outputs", {in_ready, busy, done, sample_count, err_count,
            bit_err_sum, max_abs_err}, 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle ignores in_valid", {sample_count, busy, in_ready}, 0);
        in_valid = 1'b0;

        run_vec(vecs[0], 1'b0, "all_match");
        run_vec(vecs[1], 1'b0, "mismatch");
        run_vec(vecs[2], 1'b1, "handshake");

        // Abort a run after two transfers; its data must not leak into the next run.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1;
        exact = 5'd5;  approx = 5'd4;  @(negedge clk);
        exact = 5'd16; approx = 5'd0;  @(negedge clk);
        in_valid = 1'b0;
        chk("partial run count", sample_count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", {in_ready, busy, done, sample_count, err_count,
            bit_err_sum, max_abs_err}, 0);
        @(negedge clk); rst_n = 1'b1;
        run_vec(vecs[3], 1'b0, "after_reset");

        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        in_valid2 = 1'b1; exact2 = 5'd0; approx2 = 5'd31;
        cyc = 0;
        while (!done2 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        in_valid2 = 1'b0;
        chk("sat done seen", done2, 1);
        chk("sat sample_count", sample_count2, 200);
        chk("sat err_count", err_count2, 200);
        chk("sat bit_err_sum", bit_err_sum2, 255);
        chk("sat max_abs_err", max_abs_err2, ABS_EN ? 31 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
